dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have no parameters; widths come from `DataBusBits (64) and `MemTypeBusBits in diagv2_const.vh.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-003 clk  in  1  rising-edge clock, shared with data_mem.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  pipeline MEM stage has a load/store.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_memType  in  `MemTypeBusBits  B/H/W/D/BU/HU/WU encoding.
REQ-008 req_addr  in  64  byte address.
REQ-009 req_wd  in  64  store data, right-justified.
REQ-010 req_ready  out  1  request retires this cycle; 0 = stall the pipeline.
REQ-011 resp_rd  out  64  extended load data, valid when req_valid & req_ready & !req_we.
REQ-012 misalign_fault  out  1  misaligned request seen while splitting is compiled out.
REQ-013 mem_we / mem_memType / mem_addr / mem_wd  out  1/`MemTypeBusBits/64/64  drive data_mem.
REQ-014 mem_rd  in  64  data_mem combinational read data.

Function
REQ-015 SHALL classify an access as misaligned when the address is not naturally aligned: H needs addr[0]!=0, W/WU need addr[1:0]!=0, D needs addr[2:0]!=0; B/BU are never misaligned.
REQ-016 SHALL pass an aligned request straight through in IDLE: mem_* = req_*, resp_rd = mem_rd, req_ready=1, zero added latency.
REQ-017 SHALL hold req_ready=1 and mem_we=0 in IDLE when req_valid=0.
REQ-018 SHALL implement the states IDLE, RD_HI, WR_LO and WR_HI.
REQ-019 For a misaligned request in IDLE, SHALL drive mem_addr={addr[63:3],3'b0}, MemTypeD, mem_we=0; capture mem_rd into lo_q; set req_ready=0; go to RD_HI.
REQ-020 In RD_HI, SHALL read mem_addr=base+8 (mod 2^64) with MemTypeD and capture mem_rd into hi_q.
REQ-021 For a load in RD_HI, SHALL output resp_rd from {mem_rd,lo_q}>>(8*addr[2:0]), truncated to size and sign- or zero-extended per memType; req_ready=1; go to IDLE. Load latency is 2 cycles.
REQ-022 For a store in RD_HI, SHALL go to WR_LO with req_ready=0.
REQ-023 In WR_LO, SHALL write the merged low dword to base with MemTypeD, mem_we=1.
REQ-024 In WR_HI, SHALL write the merged high dword to base+8 with MemTypeD, mem_we=1; req_ready=1; go to IDLE. Store latency is 4 cycles.
REQ-025 Merge SHALL be {hi_q,lo_q} with bytes [off, off+size) replaced by req_wd[8*size-1:0], where off=addr[2:0].
REQ-026 SHALL treat the requester as holding req_* stable while req_ready=0; the request is sampled only in IDLE, and behaviour is undefined if req_* changes mid-sequence.
REQ-027 An access that does not cross a dword boundary (e.g. H at off 1) SHALL still use the two-read split path.
REQ-028 Base+8 SHALL wrap modulo 2^64; the wrap at 0xFFFF_FFFF_FFFF_FFF8 lands on dword 0.
REQ-029 An unknown memType SHALL pass through unsplit; data_mem returns zero and performs no write.

Reset
REQ-030 Reset SHALL force state=IDLE and clear lo_q and hi_q immediately, with no clock needed.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence; a partial store may leave only the WR_LO dword written, and no further mem_we is issued.
REQ-032 While reset is high, req_ready=0, mem_we=0, misalign_fault=0.

Configuration
REQ-033 With `DMEM_MISALIGN_EN defined, SHALL provide the split FSM of REQ-018..REQ-028, and misalign_fault SHALL be constant 0.
REQ-034 With `DMEM_MISALIGN_EN undefined, SHALL omit the FSM and capture registers; every request passes through in one cycle as in REQ-016, and misalign_fault=1 in any cycle with req_valid and a misaligned access.

Verification
REQ-035 Aligned LD at 0x10, dmem[2]=0x1122334455667788 -> resp_rd=0x1122334455667788, req_ready=1 in the same cycle.
REQ-036 LW at 0x0E, dmem[1]=0x8899_AABB_CCDD_EEFF, dmem[2]=0x0000_0000_0000_0180 -> two cycles, resp_rd=0x0000_0000_0180_8899.
REQ-037 LH at 0x09 with byte9=0x00 and byte10=0xF0 -> resp_rd=0xFFFF_FFFF_FFFF_F000; LHU at 0x09 -> resp_rd=0x0000_0000_0000_F000.
REQ-038 SD at 0x0C with wd=0x0102030405060708 -> 4 cycles; dmem[1][63:32]=0x05060708 and dmem[2][31:0]=0x01020304, other bytes unchanged.
REQ-039 Reset pulsed in the WR_HI cycle of an SD at 0x0C -> dmem[2] unchanged, state=IDLE, req_ready=0 while reset is high.
REQ-040 Build without `DMEM_MISALIGN_EN, LW at 0x0E -> misalign_fault=1 and req_ready=1 for one cycle.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store front end for data_mem: aligned requests pass straight through; with
// DMEM_MISALIGN_EN defined, misaligned requests are split into dword read/merge/write sequences.
`ifndef DataBusBits
`define DataBusBits 64
`endif
`ifndef MemTypeBusBits
`define MemTypeBusBits 3
`endif

module dmem_access_ctrl (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   input  logic                       req_we,
   input  logic [`MemTypeBusBits-1:0] req_memType,
   input  logic [`DataBusBits-1:0]    req_addr,
   input  logic [`DataBusBits-1:0]    req_wd,
   output logic                       req_ready,
   output logic [`DataBusBits-1:0]    resp_rd,
   output logic                       misalign_fault,
   output logic                       mem_we,
   output logic [`MemTypeBusBits-1:0] mem_memType,
   output logic [`DataBusBits-1:0]    mem_addr,
   output logic [`DataBusBits-1:0]    mem_wd,
   input  logic [`DataBusBits-1:0]    mem_rd
);
   localparam logic [`MemTypeBusBits-1:0] MT_B  = 'd0;
   localparam logic [`MemTypeBusBits-1:0] MT_H  = 'd1;
   localparam logic [`MemTypeBusBits-1:0] MT_W  = 'd2;
   localparam logic [`MemTypeBusBits-1:0] MT_D  = 'd3;
   localparam logic [`MemTypeBusBits-1:0] MT_BU = 'd4;
   localparam logic [`MemTypeBusBits-1:0] MT_HU = 'd5;
   localparam logic [`MemTypeBusBits-1:0] MT_WU = 'd6;

   function automatic logic [3:0] size_of(input logic [`MemTypeBusBits-1:0] mt);
      case (mt)
         MT_B, MT_BU: size_of = 4'd1;
         MT_H, MT_HU: size_of = 4'd2;
         MT_W, MT_WU: size_of = 4'd4;
         MT_D:        size_of = 4'd8;
         default:     size_of = 4'd0;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [3:0] size, input logic [2:0] off);
      case (size)
         4'd2:    is_misaligned = off[0];
         4'd4:    is_misaligned = |off[1:0];
         4'd8:    is_misaligned = |off;
         default: is_misaligned = 1'b0;
      endcase
   endfunction

   logic mis;
   assign mis = is_misaligned(size_of(req_memType), req_addr[2:0]);

`ifdef DMEM_MISALIGN_EN
   typedef enum logic [1:0] {IDLE, RD_HI, WR_LO, WR_HI} state_t;

   state_t state, next_state;
   logic [63:0]  lo_q, hi_q;
   logic [63:0]  base, base_hi;
   logic [127:0] merged;

   function automatic logic [63:0] extract(input logic [127:0] pair, input logic [2:0] off,
                                           input logic [`MemTypeBusBits-1:0] mt);
      logic [127:0] sh;
      sh = pair >> {off, 3'b000};
      case (mt)
         MT_B:    extract = {{56{sh[7]}}, sh[7:0]};
         MT_BU:   extract = {56'b0, sh[7:0]};
         MT_H:    extract = {{48{sh[15]}}, sh[15:0]};
         MT_HU:   extract = {48'b0, sh[15:0]};
         MT_W:    extract = {{32{sh[31]}}, sh[31:0]};
         MT_WU:   extract = {32'b0, sh[31:0]};
         MT_D:    extract = sh[63:0];
         default: extract = 64'b0;
      endcase
   endfunction

   function automatic logic [127:0] merge(input logic [127:0] pair, input logic [63:0] wd,
                                          input logic [2:0] off, input logic [3:0] size);
      logic [63:0]  lane;
      logic [127:0] mask;
      lane = 64'b0;
      case (size)
         4'd1:    lane = 64'h0000_0000_0000_00FF;
         4'd2:    lane = 64'h0000_0000_0000_FFFF;
         4'd4:    lane = 64'h0000_0000_FFFF_FFFF;
         4'd8:    lane = 64'hFFFF_FFFF_FFFF_FFFF;
         default: lane = 64'b0;
      endcase
      mask  = {64'b0, lane} << {off, 3'b000};
      merge = (pair & ~mask) | ({64'b0, wd & lane} << {off, 3'b000});
   endfunction

   assign base    = {req_addr[63:3], 3'b000};
   assign base_hi = base + 64'd8;
   assign merged  = merge({hi_q, lo_q}, req_wd, req_addr[2:0], size_of(req_memType));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         lo_q  <= 64'b0;
         hi_q  <= 64'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && req_valid && mis)
            lo_q <= mem_rd;
         if (state == RD_HI)
            hi_q <= mem_rd;
      end
   end

   always_comb begin
      next_state     = state;
      req_ready      = 1'b1;
      resp_rd        = mem_rd;
      mem_we         = req_valid & req_we;
      mem_memType    = req_memType;
      mem_addr       = req_addr;
      mem_wd         = req_wd;
      misalign_fault = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && mis) begin
               mem_we      = 1'b0;
               mem_memType = MT_D;
               mem_addr    = base;
               req_ready   = 1'b0;
               next_state  = RD_HI;
            end
         end
         RD_HI: begin
            mem_we      = 1'b0;
            mem_memType = MT_D;
            mem_addr    = base_hi;
            if (req_we) begin
               req_ready  = 1'b0;
               next_state = WR_LO;
            end else begin
               resp_rd    = extract({mem_rd, lo_q}, req_addr[2:0], req_memType);
               next_state = IDLE;
            end
         end
         WR_LO: begin
            mem_we      = 1'b1;
            mem_memType = MT_D;
            mem_addr    = base;
            mem_wd      = merged[63:0];
            req_ready   = 1'b0;
            next_state  = WR_HI;
         end
         WR_HI: begin
            mem_we      = 1'b1;
            mem_memType = MT_D;
            mem_addr    = base_hi;
            mem_wd      = merged[127:64];
            next_state  = IDLE;
         end
         default: next_state = IDLE;
      endcase
      // Reset aborts any sequence in flight and blocks further writes.
      if (reset) begin
         req_ready = 1'b0;
         mem_we    = 1'b0;
      end
   end
`else
   logic unused_clk;
   assign unused_clk     = clk;
   assign req_ready      = ~reset;
   assign resp_rd        = mem_rd;
   assign mem_we         = ~reset & req_valid & req_we;
   assign mem_memType    = req_memType;
   assign mem_addr       = req_addr;
   assign mem_wd         = req_wd;
   assign misalign_fault = ~reset & req_valid & mis;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural data_mem plus a byte-array reference model,
// directed cases and randomized loads/stores. Adapts to DMEM_MISALIGN_EN.
`ifndef MemTypeBusBits
`define MemTypeBusBits 3
`endif

module tb_dmem_access_ctrl;
   logic                       clk = 1'b0;
   logic                       reset;
   logic                       req_valid, req_we;
   logic [`MemTypeBusBits-1:0] req_memType;
   logic [63:0]                req_addr, req_wd;
   logic                       req_ready;
   logic [63:0]                resp_rd;
   logic                       misalign_fault;
   logic                       mem_we;
   logic [`MemTypeBusBits-1:0] mem_memType;
   logic [63:0]                mem_addr, mem_wd, mem_rd;

   int n_cmp = 0;
   int n_fail = 0;

   logic [63:0] dmem [0:31];
   logic [7:0]  refmem [0:255];

`ifdef DMEM_MISALIGN_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   always #5 clk = ~clk;

   dmem_access_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_memType(req_memType), .req_addr(req_addr), .req_wd(req_wd),
      .req_ready(req_ready), .resp_rd(resp_rd), .misalign_fault(misalign_fault),
      .mem_we(mem_we), .mem_memType(mem_memType), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   function automatic int tb_size(input logic [`MemTypeBusBits-1:0] mt);
      case (int'(mt))
         0, 4:    return 1;
         1, 5:    return 2;
         2, 6:    return 4;
         3:       return 8;
         default: return 0;
      endcase
   endfunction

   // data_mem: combinational read of the addressed dword, sized and extended; sized write.
   always_comb begin
      logic [63:0] sh;
      int n;
      sh = dmem[mem_addr[7:3]] >> (8 * int'(mem_addr[2:0]));
      n = tb_size(mem_memType);
      mem_rd = 64'b0;
      for (int i = 0; i < 8; i++)
         if (i < n) mem_rd[8*i +: 8] = sh[8*i +: 8];
      if (int'(mem_memType) < 3 && n > 0 && n < 8 && sh[8*n-1])
         for (int i = 0; i < 8; i++)
            if (i >= n) mem_rd[8*i +: 8] = 8'hFF;
   end

   always @(posedge clk) begin
      if (mem_we)
         for (int i = 0; i < 8; i++)
            if (i < tb_size(mem_memType) && int'(mem_addr[2:0]) + i < 8)
               dmem[mem_addr[7:3]][8*(int'(mem_addr[2:0]) + i) +: 8] <= mem_wd[8*i +: 8];
   end

   function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] mt);
      logic [63:0] v, ai;
      int n;
      v = 64'b0;
      n = tb_size(mt);
      for (int i = 0; i < n; i++) begin
         ai = a + 64'(i);
         v[8*i +: 8] = refmem[ai[7:0]];
      end
      if (mt < 3'd3 && n > 0 && n < 8 && v[8*n-1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic ref_store(input logic [63:0] a, input logic [2:0] mt, input logic [63:0] wd);
      logic [63:0] ai;
      for (int i = 0; i < tb_size(mt); i++) begin
         ai = a + 64'(i);
         refmem[ai[7:0]] = wd[8*i +: 8];
      end
   endtask

   function automatic logic [63:0] ref_dword(input int k);
      logic [63:0] v;
      for (int j = 0; j < 8; j++) v[8*j +: 8] = refmem[8*k + j];
      return v;
   endfunction

   task automatic poke(input int k, input logic [63:0] v);
      dmem[k] = v;
      for (int j = 0; j < 8; j++) refmem[8*k + j] = v[8*j +: 8];
   endtask

   function automatic bit ref_mis(input logic [63:0] a, input logic [2:0] mt);
      int n;
      n = tb_size(mt);
      return n > 1 && (int'(a[2:0]) % n) != 0;
   endfunction

   // Issue one request at posedge+1; returns cycles until req_ready (0 = never).
   task automatic do_req(input logic we, input logic [2:0] mt, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd, output int lat,
                         output logic flt);
      bit done;
      int cyc;
      req_valid = 1'b1; req_we = we; req_memType = mt; req_addr = a; req_wd = wd;
      done = 1'b0; cyc = 0; lat = 0; rd = 64'b0; flt = 1'b0;
      while (!done && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (req_ready) begin
            rd = resp_rd; flt = misalign_fault; lat = cyc; done = 1'b1;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_memType = 3'd2;
      req_addr = 64'h0E; req_wd = 64'h0;
      #3;
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      n_cmp++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", misalign_fault); end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_mem_we got=%b exp=0", mem_we); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [63:0] rd;
      int lat;
      logic flt;
      poke(2, 64'h1122334455667788);
      do_req(1'b0, 3'd3, 64'h10, 64'h0, rd, lat, flt);
      n_cmp++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld_aligned got=%h exp=1122334455667788", rd); end
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ld_aligned_lat got=%0d exp=1", lat); end
      poke(1, 64'h8899AABBCCDDEEFF);
      poke(2, 64'h0000000000000180);
      do_req(1'b0, 3'd2, 64'h0E, 64'h0, rd, lat, flt);
      n_cmp++; if (lat !== (SPLIT ? 2 : 1)) begin n_fail++; $display("FAIL lw_0e_lat got=%0d exp=%0d", lat, SPLIT ? 2 : 1); end
      n_cmp++; if (flt !== !SPLIT) begin n_fail++; $display("FAIL lw_0e_fault got=%b exp=%b", flt, !SPLIT); end
      if (SPLIT) begin
         n_cmp++; if (rd !== 64'h0000000001808899) begin n_fail++; $display("FAIL lw_0e got=%h exp=0000000001808899", rd); end
         refmem[9] = 8'h00; refmem[10] = 8'hF0;
         dmem[1][15:8] = 8'h00; dmem[1][23:16] = 8'hF0;
         do_req(1'b0, 3'd1, 64'h09, 64'h0, rd, lat, flt);
         n_cmp++; if (rd !== 64'hFFFFFFFFFFFFF000) begin n_fail++; $display("FAIL lh_09 got=%h exp=FFFFFFFFFFFFF000", rd); end
         do_req(1'b0, 3'd5, 64'h09, 64'h0, rd, lat, flt);
         n_cmp++; if (rd !== 64'h000000000000F000) begin n_fail++; $display("FAIL lhu_09 got=%h exp=000000000000F000", rd); end
         do_req(1'b1, 3'd3, 64'h0C, 64'h0102030405060708, rd, lat, flt);
         ref_store(64'h0C, 3'd3, 64'h0102030405060708);
         n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL sd_0c_lat got=%0d exp=4", lat); end
         n_cmp++; if (dmem[1][63:32] !== 32'h05060708) begin n_fail++; $display("FAIL sd_0c_lo got=%h exp=05060708", dmem[1][63:32]); end
         n_cmp++; if (dmem[2][31:0] !== 32'h01020304) begin n_fail++; $display("FAIL sd_0c_hi got=%h exp=01020304", dmem[2][31:0]); end
         poke(31, 64'hA1A2A3A4A5A6A7A8);
         poke(0, 64'hB1B2B3B4B5B6B7B8);
         do_req(1'b0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 64'h0, rd, lat, flt);
         n_cmp++; if (rd !== 64'hB5B6B7B8A1A2A3A4) begin n_fail++; $display("FAIL ld_wrap got=%h exp=B5B6B7B8A1A2A3A4", rd); end
      end
      do_req(1'b1, 3'd7, 64'h18, 64'hDEADBEEFDEADBEEF, rd, lat, flt);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL unk_st_lat got=%0d exp=1", lat); end
      do_req(1'b0, 3'd7, 64'h13, 64'h0, rd, lat, flt);
      n_cmp++; if (rd !== 64'h0) begin n_fail++; $display("FAIL unk_ld got=%h exp=0", rd); end
      n_cmp++; if (flt !== 1'b0) begin n_fail++; $display("FAIL unk_ld_fault got=%b exp=0", flt); end
   endtask

   task automatic test_reset_mid_store();
      logic [63:0] rd, exp_hi, exp_lo;
      int lat;
      logic flt;
      poke(1, {$urandom, $urandom});
      poke(2, {$urandom, $urandom});
      exp_hi = dmem[2];
      req_valid = 1'b1; req_we = 1'b1; req_memType = 3'd3;
      req_addr = 64'h0C; req_wd = 64'h0102030405060708;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", req_ready); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_we got=%b exp=0", mem_we); end
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; reset = 1'b0;
      for (int i = 0; i < 4; i++) refmem[12 + i] = req_wd[8*i +: 8];
      exp_lo = ref_dword(1);
      n_cmp++; if (dmem[2] !== exp_hi) begin n_fail++; $display("FAIL midrst_hi got=%h exp=%h", dmem[2], exp_hi); end
      n_cmp++; if (dmem[1] !== exp_lo) begin n_fail++; $display("FAIL midrst_lo got=%h exp=%h", dmem[1], exp_lo); end
      @(posedge clk); #1;
      do_req(1'b0, 3'd3, 64'h10, 64'h0, rd, lat, flt);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL midrst_idle_lat got=%0d exp=1", lat); end
      n_cmp++; if (rd !== exp_hi) begin n_fail++; $display("FAIL midrst_idle_rd got=%h exp=%h", rd, exp_hi); end
   endtask

   task automatic test_random();
      logic [63:0] a, wd, rd, exp_rd;
      logic [2:0]  mt;
      logic        we, flt, mis;
      int lat, n, exp_lat;
      for (int it = 0; it < 80; it++) begin
         mt = 3'($urandom_range(0, 6));
         n  = tb_size(mt);
         a  = {$urandom, $urandom};
         wd = {$urandom, $urandom};
         we = 1'($urandom_range(0, 1));
         if (!SPLIT && we) a = a & ~(64'(n) - 64'd1);
         mis = ref_mis(a, mt);
         exp_rd = ref_load(a, mt);
         exp_lat = (SPLIT && mis) ? (we ? 4 : 2) : 1;
         do_req(we, mt, a, wd, rd, lat, flt);
         n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat it=%0d got=%0d exp=%0d", it, lat, exp_lat); end
         n_cmp++; if (flt !== (!SPLIT && mis)) begin n_fail++; $display("FAIL rnd_fault it=%0d got=%b exp=%b", it, flt, !SPLIT && mis); end
         if (!we && (SPLIT || !mis)) begin
            n_cmp++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_ld it=%0d a=%h mt=%0d got=%h exp=%h", it, a, mt, rd, exp_rd); end
         end
         if (we) ref_store(a, mt, wd);
      end
   endtask

   task automatic test_memory_image();
      for (int k = 0; k < 32; k++) begin
         n_cmp++;
         if (dmem[k] !== ref_dword(k)) begin
            n_fail++; $display("FAIL mem_image k=%0d got=%h exp=%h", k, dmem[k], ref_dword(k));
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 32; k++) poke(k, {$urandom, $urandom});
      test_reset();
      test_directed();
      test_reset_mid_store();
      test_random();
      test_memory_image();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
